// File: rtl/decode_stage.sv
// Instruction decode stage: two-entry skid buffer (OUT + SKID) with a registered
// in_ready, decoding opcode into immediate format, register indices and use flags.
module decode_stage #(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  logic [31:0]         in_inst,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [31:0]         out_inst,
    output logic [2:0]          out_imm_type,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [4:0]          out_rd,
    output logic                out_uses_rs1,
    output logic                out_uses_rs2,
    output logic                out_writes_rd,
    output logic                out_illegal
);

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Packed result: [6] illegal, [5] writes_rd, [4] uses_rs2, [3] uses_rs1, [2:0] imm_type.
    // Every legal opcode ends in 2'b11, so a bad inst[1:0] falls into the default arm.
    function automatic logic [6:0] decode_fn(input logic [31:0] inst);
        logic [2:0] imm;
        logic       r1;
        logic       r2;
        logic       wr;
        logic       ill;
        imm = IMM_NONE;
        r1  = 1'b0;
        r2  = 1'b0;
        wr  = 1'b0;
        ill = 1'b0;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC: begin imm = IMM_U; wr = 1'b1; end
            OPC_JAL:            begin imm = IMM_J; wr = 1'b1; end
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_SYSTEM:
                                begin imm = IMM_I; r1 = 1'b1; wr = 1'b1; end
            OPC_BRANCH:         begin imm = IMM_B; r1 = 1'b1; r2 = 1'b1; end
            OPC_STORE:          begin imm = IMM_S; r1 = 1'b1; r2 = 1'b1; end
            OPC_OP:             begin r1 = 1'b1; r2 = 1'b1; wr = 1'b1; end
            default:            ill = 1'b1;
        endcase
        wr = wr & (inst[11:7] != 5'd0);
        return {ill, wr, r2, r1, imm};
    endfunction

    logic [1:0]          state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic [PC_WIDTH-1:0] skid_pc_q;
    logic [31:0]         skid_inst_q;
    logic [PC_WIDTH-1:0] out_pc_q;
    logic [31:0]         out_inst_q;
    logic [2:0]          out_imm_q;
    logic                out_r1_q, out_r2_q, out_wr_q, out_ill_q;

    logic                accept_s, take_s;
    logic                load_out_s, load_skid_s, from_skid_s;
    logic [PC_WIDTH-1:0] src_pc_s;
    logic [31:0]         src_inst_s;
    logic [6:0]          dec_s;

    assign accept_s   = in_valid & in_ready_q;
    assign take_s     = out_valid_q & out_ready;
    assign src_pc_s   = from_skid_s ? skid_pc_q : in_pc;
    assign src_inst_s = from_skid_s ? skid_inst_q : in_inst;
    assign dec_s      = decode_fn(src_inst_s);

    // Buffer occupancy and load steering; flush overrides every handshake.
    always_comb begin
        state_d     = state_q;
        load_out_s  = 1'b0;
        load_skid_s = 1'b0;
        from_skid_s = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d    = ST_ONE;
                        load_out_s = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && take_s) begin
                        load_out_s = 1'b1;
                    end else if (accept_s) begin
                        state_d     = ST_FULL;
                        load_skid_s = 1'b1;
                    end else if (take_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (take_s) begin
                        state_d     = ST_ONE;
                        load_out_s  = 1'b1;
                        from_skid_s = 1'b1;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign out_valid_d = (state_d != ST_EMPTY);
    assign in_ready_d  = (state_d != ST_FULL);

    // Control registers: state, output valid and the registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Skid entry holds the raw instruction; it is decoded only on its move to OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_pc_q   <= {PC_WIDTH{1'b0}};
            skid_inst_q <= 32'd0;
        end else if (load_skid_s) begin
            skid_pc_q   <= in_pc;
            skid_inst_q <= in_inst;
        end
    end

    // OUT entry with decoded fields; holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pc_q   <= {PC_WIDTH{1'b0}};
            out_inst_q <= 32'd0;
            out_imm_q  <= IMM_NONE;
            out_r1_q   <= 1'b0;
            out_r2_q   <= 1'b0;
            out_wr_q   <= 1'b0;
            out_ill_q  <= 1'b0;
        end else if (load_out_s) begin
            out_pc_q   <= src_pc_s;
            out_inst_q <= src_inst_s;
            out_imm_q  <= dec_s[2:0];
            out_r1_q   <= dec_s[3];
            out_r2_q   <= dec_s[4];
            out_wr_q   <= dec_s[5];
            out_ill_q  <= dec_s[6];
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_pc        = out_pc_q;
    assign out_inst      = out_inst_q;
    assign out_imm_type  = out_imm_q;
    assign out_rs1       = out_inst_q[19:15];
    assign out_rs2       = out_inst_q[24:20];
    assign out_rd        = out_inst_q[11:7];
    assign out_uses_rs1  = out_r1_q;
    assign out_uses_rs2  = out_r2_q;
    assign out_writes_rd = out_wr_q;
    assign out_illegal   = out_ill_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed decode table, backpressure/flush/reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = 32'd0;
    logic [31:0] in_inst = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  out_imm_type;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal;

    decode_stage #(.PC_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_imm_type(out_imm_type), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_uses_rs1(out_uses_rs1), .out_uses_rs2(out_uses_rs2),
        .out_writes_rd(out_writes_rd), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct packed { logic ill; logic wr; logic r2; logic r1; logic [2:0] imm; } dec_t;
    typedef struct { logic [6:0] opc; logic [2:0] imm; logic r1; logic r2; logic wr; } rule_t;
    typedef struct {
        logic [31:0] inst; logic [2:0] imm; logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd;
        logic u1; logic u2; logic wr; logic ill;
    } vec_t;

    int          n_checks = 0;
    int          n_pass = 0;
    ent_t        mq[$];
    logic [31:0] emitted[$];
    int          acc_cnt = 0;
    logic        last_acc = 1'b0;
    rule_t       rules[10];
    vec_t        vecs[14];
    logic [6:0]  rnd_opc[13];
    logic [31:0] bp_pcs[4];
    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic dec_t ref_dec(input logic [31:0] inst);
        dec_t d;
        logic found;
        d = '0;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (rules[k].opc == inst[6:0]) begin
                d.imm = rules[k].imm;
                d.r1  = rules[k].r1;
                d.r2  = rules[k].r2;
                d.wr  = rules[k].wr && (inst[11:7] != 5'd0);
                found = 1'b1;
            end
        end
        d.ill = !found;
        return d;
    endfunction

    task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic check_model(input string name);
        dec_t d;
        ent_t e;
        if (mq.size() > 0) begin
            e = mq[0];
            d = ref_dec(e.inst);
            chk(name,
                192'({out_valid, in_ready, out_pc, out_inst, out_imm_type, out_rs1, out_rs2, out_rd,
                      out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal}),
                192'({1'b1, (mq.size() < 2), e.pc, e.inst, d.imm, e.inst[19:15], e.inst[24:20],
                      e.inst[11:7], d.r1, d.r2, d.wr, d.ill}));
        end else begin
            chk(name, 192'({out_valid, in_ready}), 192'({1'b0, 1'b1}));
        end
    endtask

    // One clock: drive at the falling edge, advance the model, check at the next falling edge.
    task automatic cycle(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                         input logic ordy, input logic fl);
        logic acc;
        logic tk;
        in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy; flush = fl;
        acc = iv && (mq.size() < 2);
        tk  = ordy && (mq.size() > 0);
        last_acc = acc && !fl;
        if (fl) begin
            mq.delete();
        end else begin
            if (tk) begin
                emitted.push_back(mq[0].pc);
                void'(mq.pop_front());
            end
            if (acc) begin
                mq.push_back('{pc: pc, inst: inst});
                acc_cnt++;
            end
        end
        @(negedge clk);
        check_model("model");
    endtask

    initial begin
        int idx;
        logic [31:0] r;
        logic [31:0] ri;
        rules[0] = '{7'b0110111, 3'd4, 1'b0, 1'b0, 1'b1};
        rules[1] = '{7'b0010111, 3'd4, 1'b0, 1'b0, 1'b1};
        rules[2] = '{7'b1101111, 3'd5, 1'b0, 1'b0, 1'b1};
        rules[3] = '{7'b1100111, 3'd1, 1'b1, 1'b0, 1'b1};
        rules[4] = '{7'b1100011, 3'd3, 1'b1, 1'b1, 1'b0};
        rules[5] = '{7'b0000011, 3'd1, 1'b1, 1'b0, 1'b1};
        rules[6] = '{7'b0100011, 3'd2, 1'b1, 1'b1, 1'b0};
        rules[7] = '{7'b0010011, 3'd1, 1'b1, 1'b0, 1'b1};
        rules[8] = '{7'b0110011, 3'd0, 1'b1, 1'b1, 1'b1};
        rules[9] = '{7'b1110011, 3'd1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 10; k++) rnd_opc[k] = rules[k].opc;
        rnd_opc[10] = 7'h00; rnd_opc[11] = 7'h0B; rnd_opc[12] = 7'h10;
        //            inst           imm   rs1    rs2    rd     u1    u2    wr    ill
        vecs[0]  = '{32'h00500093, 3'd1, 5'd0, 5'd5, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{32'h0020A423, 3'd2, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{32'h0000006F, 3'd5, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'h00000000, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{32'h000010B7, 3'd4, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{32'h00000297, 3'd4, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{32'h000080E7, 3'd1, 5'd1, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{32'h00208463, 3'd3, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{32'h0000A103, 3'd1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{32'h002081B3, 3'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{32'h00000073, 3'd1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{32'h00500090, 3'd0, 5'd0, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{32'h0000000B, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{32'h008000EF, 3'd5, 5'd0, 5'd8, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        bp_pcs[0] = 32'h0; bp_pcs[1] = 32'h4; bp_pcs[2] = 32'h8; bp_pcs[3] = 32'hC;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_state",
            192'({out_valid, in_ready, out_pc, out_inst, out_imm_type, out_rs1, out_rs2, out_rd,
                  out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal}),
            192'({1'b0, 1'b1, 32'd0, 32'd0, 3'd0, 15'd0, 4'd0}));

        // Decode table, back-to-back with out_ready high
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, 32'(i * 4), vecs[i].inst, 1'b1, 1'b0);
            chk($sformatf("decode_%0d", i),
                192'({out_valid, out_imm_type, out_rs1, out_rs2, out_rd,
                      out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal}),
                192'({1'b1, vecs[i].imm, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                      vecs[i].u1, vecs[i].u2, vecs[i].wr, vecs[i].ill}));
        end
        cycle(1'b0, 32'd0, NOP, 1'b1, 1'b0);

        // Backpressure: 3 stalled cycles accept exactly two, then drain in order
        emitted.delete(); acc_cnt = 0;
        cycle(1'b1, bp_pcs[0], NOP, 1'b0, 1'b0);
        cycle(1'b1, bp_pcs[1], NOP, 1'b0, 1'b0);
        cycle(1'b1, bp_pcs[2], NOP, 1'b0, 1'b0);
        chk("bp_accepted", 192'(acc_cnt), 192'(2));
        chk("bp_full", 192'({in_ready, out_valid, out_pc}), 192'({1'b0, 1'b1, 32'h0}));
        idx = 2;
        for (int k = 0; k < 20 && emitted.size() < 4; k++) begin
            cycle(idx < 4, (idx < 4) ? bp_pcs[idx] : 32'd0, NOP, 1'b1, 1'b0);
            if (last_acc) idx++;
        end
        chk("bp_order", 192'({32'(emitted.size()), emitted[0], emitted[1], emitted[2], emitted[3]}),
            192'({32'd4, 32'h0, 32'h4, 32'h8, 32'hC}));

        // Flush of a full buffer drops everything including the offered PC 0x40
        emitted.delete();
        cycle(1'b1, 32'h20, NOP, 1'b0, 1'b0);
        cycle(1'b1, 32'h24, NOP, 1'b0, 1'b0);
        chk("flush_pre_full", 192'({in_ready, out_valid}), 192'({1'b0, 1'b1}));
        cycle(1'b1, 32'h40, NOP, 1'b0, 1'b1);
        chk("flush_empty", 192'({out_valid, in_ready}), 192'({1'b0, 1'b1}));
        cycle(1'b1, 32'h100, NOP, 1'b1, 1'b0);
        chk("flush_next", 192'({out_valid, out_pc}), 192'({1'b1, 32'h100}));
        cycle(1'b0, 32'd0, NOP, 1'b1, 1'b0);
        chk("flush_emitted", 192'({32'(emitted.size()), emitted[0]}), 192'({32'd1, 32'h100}));

        // Asynchronous reset mid-stream
        cycle(1'b1, 32'h200, NOP, 1'b0, 1'b0);
        chk("rst_pre", 192'({out_valid, out_pc}), 192'({1'b1, 32'h200}));
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk("rst_async", 192'({out_valid, in_ready}), 192'({1'b0, 1'b1}));
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
        check_model("rst_held");
        cycle(1'b1, 32'h300, 32'h00500093, 1'b1, 1'b0);
        chk("rst_resume", 192'({out_valid, out_pc}), 192'({1'b1, 32'h300}));
        cycle(1'b0, 32'd0, NOP, 1'b1, 1'b0);

        // Randomized traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            r  = $urandom();
            ri = $urandom();
            cycle($urandom_range(0, 3) != 0, r & 32'hFFFF_FFFC,
                  {ri[31:7], rnd_opc[$urandom_range(0, 12)]},
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
